// File: rtl/rmii_rx_framer_if.sv
// rmii_rx_framer_if: RMII receive pins plus the framed byte stream toward the MAC buffer.
interface rmii_rx_framer_if;
    logic        crs_dv;
    logic [1:0]  rx_d;
    logic        rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [10:0] rx_len;
    logic        rx_drop;
    modport master (input crs_dv, rx_d, rx_er, output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_drop);
    modport slave (output crs_dv, rx_d, rx_er, input rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_drop);
endinterface

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: strips preamble/SFD from RMII dibits and emits bytes with sof/eof/err/len framing.
module rmii_rx_framer #(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MIN_FRAME_LEN = 64,
    parameter int PREAMBLE_MIN  = 8
) (
    input logic clk,
    input logic rst,
    rmii_rx_framer_if.master bus
);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
    localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
    state_t      state, state_n;
    logic        s_dv, s_er, valid;
    logic [1:0]  s_d;
    logic [3:0]  pre_cnt, pre_cnt_n;
    logic [1:0]  dib_idx, dib_idx_n;
    logic [7:0]  byte_sr, byte_sr_n, hold, hold_n, shifted;
    logic [10:0] byte_cnt, byte_cnt_n;
    logic        err, err_n;
    logic [7:0]  data_q, data_n;
    logic [10:0] len_q, len_n;
    logic        valid_q, valid_n, sof_q, sof_n, eof_q, eof_n, perr_q, perr_n, drop_q, drop_n;
    // crs_dv toggles at carrier loss, so a dibit stays valid if either its own or the next crs_dv is high
    assign valid   = s_dv | bus.crs_dv;
    assign shifted = {s_d, byte_sr[7:2]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s_dv, s_d, s_er} <= '0;
            state    <= IDLE;
            pre_cnt  <= '0;
            dib_idx  <= '0;
            byte_sr  <= '0;
            hold     <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
            {data_q, len_q, valid_q, sof_q, eof_q, perr_q, drop_q} <= '0;
        end else begin
            {s_dv, s_d, s_er} <= {bus.crs_dv, bus.rx_d, bus.rx_er};
            state    <= state_n;
            pre_cnt  <= pre_cnt_n;
            dib_idx  <= dib_idx_n;
            byte_sr  <= byte_sr_n;
            hold     <= hold_n;
            byte_cnt <= byte_cnt_n;
            err      <= err_n;
            {data_q, len_q, valid_q, sof_q, eof_q, perr_q, drop_q} <=
                {data_n, len_n, valid_n, sof_n, eof_n, perr_n, drop_n};
        end
    end
    always_comb begin
        state_n    = state;
        pre_cnt_n  = pre_cnt;
        dib_idx_n  = dib_idx;
        byte_sr_n  = byte_sr;
        hold_n     = hold;
        byte_cnt_n = byte_cnt;
        err_n      = err;
        data_n     = data_q;
        len_n      = len_q;
        sof_n      = sof_q;
        eof_n      = eof_q;
        perr_n     = perr_q;
        valid_n    = 1'b0;
        drop_n     = 1'b0;
        case (state)
            IDLE: begin
                byte_cnt_n = '0;
                if (valid && s_d == 2'b01) begin
                    state_n   = PRE;
                    pre_cnt_n = 4'd1;
                end else if (valid && s_d != 2'b00) begin
                    state_n = DROP;
                end
            end
            PRE: begin
                if (!valid) begin
                    state_n = IDLE;
                    drop_n  = 1'b1;
                end else if (s_d == 2'b01) begin
                    pre_cnt_n = (pre_cnt == 4'd15) ? pre_cnt : pre_cnt + 4'd1;
                end else if (s_d == 2'b11 && pre_cnt >= PRE_MIN) begin
                    state_n    = DATA;
                    dib_idx_n  = '0;
                    byte_cnt_n = '0;
                    err_n      = 1'b0;
                end else begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (!valid) begin
                    state_n = IDLE;
                    drop_n  = (byte_cnt == '0);
                    valid_n = (byte_cnt != '0);
                    if (byte_cnt != '0) begin
                        data_n = hold;
                        sof_n  = (byte_cnt == 11'd1);
                        eof_n  = 1'b1;
                        len_n  = byte_cnt;
                        perr_n = err | (dib_idx != 2'd0) | (byte_cnt < MIN_LEN);
                    end
                end else begin
                    byte_sr_n = shifted;
                    dib_idx_n = dib_idx + 2'd1;
                    err_n     = err | s_er;
                    // one-byte hold lets the final byte carry eof once carrier drops
                    if (dib_idx == 2'd3) begin
                        hold_n  = shifted;
                        valid_n = (byte_cnt != '0);
                        if (byte_cnt != '0) begin
                            data_n = hold;
                            sof_n  = (byte_cnt == 11'd1);
                            eof_n  = 1'b0;
                            perr_n = 1'b0;
                            len_n  = byte_cnt;
                        end
                        if (byte_cnt == MAX_LEN) begin
                            eof_n   = 1'b1;
                            perr_n  = 1'b1;
                            state_n = DROP;
                        end else begin
                            byte_cnt_n = byte_cnt + 11'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (!valid) begin
                    state_n = IDLE;
                    drop_n  = (byte_cnt == '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;
    assign bus.rx_sof   = sof_q;
    assign bus.rx_eof   = eof_q;
    assign bus.rx_err   = perr_q;
    assign bus.rx_len   = len_q;
    assign bus.rx_drop  = drop_q;
endmodule
